regfile_mp: RTL and testbench

Parametrised multi-read-port register file, the successor to the team's fixed 16x32 dual-read register file. It provides NUM_RD registered read ports, one write port with byte enables, a read-valid strobe, and a sequenced bulk-clear engine with a busy flag. Optional same-cycle write-to-read forwarding is available. It sits between the datapath decode stage and the execution operand latches.

---
 rtl/regfile_mp.sv | 155 +++++++++++++++
 tb/tb_regfile_mp.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
// regfile_mp: parametrised register file with NUM_RD registered read ports, one byte-enabled write port and a sequenced bulk clear.
// Latency: reads 1 cycle (rd_data/rd_valid in the cycle after the request); a write is visible to the next cycle's read; a clear takes DEPTH cycles.
// Backpressure: none; wr/rd are dropped while busy=1 or en=0, and en=0 freezes the clear sweep. Optional macro REGFILE_MP_BYPASS_EN forwards same-cycle write data to a colliding read.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic                     rd,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int NB = DATA_W / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_W-1:0]        clr_cnt;
    logic [ADDR_W-1:0]        clr_cnt_nxt;
    logic                     clr_step;

    logic [DATA_W-1:0]        mem [DEPTH];

    logic                     idle;
    logic                     acc_clr;
    logic                     acc_wr;
    logic                     acc_rd;
    logic                     wr_in_range;
    logic [DATA_W-1:0]        wr_merged;
    logic [NUM_RD*DATA_W-1:0] rd_data_nxt;

    // Addresses past DEPTH exist only for non-power-of-two depths; widen before comparing.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH);
    endfunction

    // A pending clear request takes the cycle: wr/rd arriving alongside it are dropped.
    assign idle        = (state == ST_IDLE);
    assign acc_clr     = en && clr_req && idle;
    assign acc_wr      = en && wr && idle && !clr_req;
    assign acc_rd      = en && rd && idle && !clr_req;
    assign wr_in_range = in_range(wr_addr);

    // Old entry with the enabled bytes replaced; used for the write and for forwarding.
    always_comb begin
        wr_merged = wr_in_range ? mem[wr_addr] : '0;
        for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) begin
                wr_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // Clear sequencer next state: one entry per enabled cycle, back to idle after the last entry.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc_clr) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (en) begin
                    clr_step = 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state_nxt   = ST_IDLE;
                        clr_cnt_nxt = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Sequencer state, sweep index and the registered busy flag (tracks the state register).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            busy    <= (state_nxt == ST_CLEAR);
        end
    end

    // Storage: reset clears everything, the sweep clears one entry, otherwise byte-merged writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_step) begin
            mem[clr_cnt] <= '0;
        end else if (acc_wr && wr_in_range) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // Per-port read mux; out-of-range ports return zero, colliding ports may see the new value.
    always_comb begin
        rd_data_nxt = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (in_range(rd_addr[p*ADDR_W +: ADDR_W])) begin
                rd_data_nxt[p*DATA_W +: DATA_W] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
                if (acc_wr && wr_in_range && (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr)) begin
                    rd_data_nxt[p*DATA_W +: DATA_W] = wr_merged;
                end
`endif
            end
        end
    end

    // Read output registers: data holds between accepted reads, valid is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= acc_rd;
            if (acc_rd) begin
                rd_data <= rd_data_nxt;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
// tb_regfile_mp: self-checking bench for regfile_mp (default 16x32x2 instance plus a 12x16x3 instance).
// Expected read data is queued when a read is driven and popped when rd_valid is due one cycle later.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;

    logic        en, wr, rd, clr_req;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic        rd_valid, busy;

    logic        p_en, p_wr, p_rd, p_clr_req;
    logic [3:0]  p_wr_addr;
    logic [15:0] p_wr_data;
    logic [1:0]  p_wr_be;
    logic [11:0] p_rd_addr;
    logic [47:0] p_rd_data;
    logic        p_rd_valid, p_busy;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] mdl [16];
    logic [63:0] sq[$];
    logic [47:0] psq[$];

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_mp #(.DATA_W(16), .DEPTH(12), .NUM_RD(3)) dut_p (
        .clk(clk), .rst(rst), .en(p_en), .wr(p_wr), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .wr_be(p_wr_be), .rd(p_rd), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_valid(p_rd_valid),
        .clr_req(p_clr_req), .busy(p_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        en = 1'b1; wr = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd = 1'b0; rd_addr = '0; clr_req = 1'b0;
        p_en = 1'b1; p_wr = 1'b0; p_wr_addr = '0; p_wr_data = '0; p_wr_be = '0;
        p_rd = 1'b0; p_rd_addr = '0; p_clr_req = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr = 1'b0;
        for (int k = 0; k < 4; k++) if (be[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic do_read(input logic [3:0] a0, input logic [3:0] a1);
        rd = 1'b1; rd_addr = {a1, a0};
        sq.push_back({mdl[a1], mdl[a0]});
        tick();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] exp;
        idle_in();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b rd_valid=%b rd_data=%h, required 0/0/0", busy, rd_valid, rd_data);
        end
        checks++;
        if (p_busy !== 1'b0 || p_rd_valid !== 1'b0 || p_rd_data !== 48'h0) begin
            errors++;
            $display("FAIL reset_state_p busy=%b rd_valid=%b rd_data=%h, required 0/0/0", p_busy, p_rd_valid, p_rd_data);
        end
        rst = 1'b0;
        model_clear();
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), 4'(15 - a));
            exp = sq.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_read a=%0d valid=%b busy=%b data=%h, required 1/0/%h", a, rd_valid, busy, rd_data, exp);
            end
        end
    endtask

    task automatic test_byte_en();
        logic [63:0] exp;
        do_write(4'd0, 32'hABCDEFAB, 4'hF);
        do_write(4'd1, 32'h01234567, 4'hF);
        do_write(4'd1, 32'h000000FF, 4'h1);
        rd = 1'b1; rd_addr = {4'd1, 4'd0};
        sq.push_back({32'h012345FF, 32'hABCDEFAB});
        tick();
        rd = 1'b0;
        exp = sq.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL byte_en valid=%b data=%h, required 1/%h", rd_valid, rd_data, exp);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== exp) begin
            errors++;
            $display("FAIL read_hold valid=%b data=%h, required 0/%h", rd_valid, rd_data, exp);
        end
    endtask

    task automatic test_collision();
        logic [63:0] exp;
        logic [31:0] exp0;
        do_write(4'd3, 32'h11111111, 4'hF);
`ifdef REGFILE_MP_BYPASS_EN
        exp0 = 32'h22221111;
`else
        exp0 = 32'h11111111;
`endif
        wr = 1'b1; wr_addr = 4'd3; wr_data = 32'h22222222; wr_be = 4'hC;
        rd = 1'b1; rd_addr = {4'd0, 4'd3};
        sq.push_back({mdl[0], exp0});
        tick();
        wr = 1'b0; rd = 1'b0;
        mdl[3][31:16] = 16'h2222;
        exp = sq.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL collision valid=%b data=%h, required 1/%h", rd_valid, rd_data, exp);
        end
        do_read(4'd3, 4'd3);
        exp = sq.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {32'h22221111, 32'h22221111} || rd_data !== exp) begin
            errors++;
            $display("FAIL collision_after valid=%b data=%h, required 1/%h", rd_valid, rd_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) do_write(4'(8 + i), 32'hC0DE0000 + 32'(i * 17), 4'hF);
        exp = '0;
        for (int i = 0; i < 4; i++) begin
            rd = 1'b1; rd_addr = {4'(11 - i), 4'(8 + i)};
            sq.push_back({mdl[11 - i], mdl[8 + i]});
            tick();
            exp = sq.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL back_to_back i=%0d valid=%b data=%h, required 1/%h", i, rd_valid, rd_data, exp);
            end
        end
        rd = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== exp) begin
            errors++;
            $display("FAIL b2b_end valid=%b data=%h, required 0/%h", rd_valid, rd_data, exp);
        end
    endtask

    task automatic test_clear();
        logic [63:0] exp;
        int          cnt;
        int          bad_vld;
        for (int i = 0; i < 16; i++) do_write(4'(i), 32'h10203040 + 32'(i) * 32'h01010101, 4'hF);
        clr_req = 1'b1; rd = 1'b1; rd_addr = {4'd2, 4'd1};
        tick();
        clr_req = 1'b0; rd = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_start valid=%b busy=%b, required 0/1", rd_valid, busy);
        end
        cnt = 0; bad_vld = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            en = !(cnt >= 8 && cnt < 11);
            wr = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
            rd = 1'b1; rd_addr = {4'd5, 4'd5};
            clr_req = (cnt == 12);
            tick();
            if (rd_valid !== 1'b0) bad_vld++;
        end
        idle_in();
        checks++;
        if (cnt !== 19 || bad_vld !== 0) begin
            errors++;
            $display("FAIL clear_busy busy_cycles=%0d valid_hits=%0d, required 19/0", cnt, bad_vld);
        end
        model_clear();
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), 4'(a));
            exp = sq.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL clear_read a=%0d valid=%b data=%h, required 1/%h", a, rd_valid, rd_data, exp);
            end
        end
    endtask

    task automatic test_rst_mid_clear();
        logic [63:0] exp;
        int          nz;
        do_write(4'd2, 32'h0BADF00D, 4'hF);
        do_write(4'd9, 32'h5EEDFACE, 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear busy=%b valid=%b, required 0/0", busy, rd_valid);
        end
        model_clear();
        nz = 0;
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), 4'(a));
            exp = sq.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp) nz++;
        end
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL rst_clear_reads bad_reads=%0d, required 0", nz);
        end
        do_write(4'd7, 32'hCAFEBABE, 4'hF);
        do_read(4'd7, 4'd2);
        exp = sq.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {32'h0, 32'hCAFEBABE} || rd_data !== exp) begin
            errors++;
            $display("FAIL rst_then_access valid=%b data=%h, required 1/%h", rd_valid, rd_data, exp);
        end
    endtask

    task automatic test_param();
        logic [47:0] exp;
        p_wr = 1'b1; p_wr_addr = 4'd13; p_wr_data = 16'h5A5A; p_wr_be = 2'b11;
        tick();
        p_wr_addr = 4'd11; p_wr_data = 16'h1234;
        tick();
        p_wr = 1'b0;
        p_rd = 1'b1; p_rd_addr = {4'd13, 4'd11, 4'd11};
        psq.push_back({16'h0000, 16'h1234, 16'h1234});
        tick();
        p_rd = 1'b0;
        exp = psq.pop_front();
        checks++;
        if (p_rd_valid !== 1'b1 || p_rd_data !== exp) begin
            errors++;
            $display("FAIL param_read valid=%b data=%h, required 1/%h", p_rd_valid, p_rd_data, exp);
        end
        p_rd = 1'b1; p_rd_addr = {4'd1, 4'd5, 4'd0};
        psq.push_back({16'h0000, 16'h0000, 16'h0000});
        tick();
        p_rd = 1'b0;
        exp = psq.pop_front();
        checks++;
        if (p_rd_valid !== 1'b1 || p_rd_data !== exp) begin
            errors++;
            $display("FAIL param_no_alias valid=%b data=%h, required 1/%h", p_rd_valid, p_rd_data, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_en();
        test_collision();
        test_back_to_back();
        test_clear();
        test_rst_mid_clear();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
